// File: rtl/temp_sensor_poller_pkg.sv
// Shared constants, FSM encoding and helpers for the ADT7311 poller.
package temp_sensor_poller_pkg;

    localparam logic [7:0]  ADT_CMD_RD_TEMP = 8'h50;
    localparam int          ADT_RST_BITS    = 32;
    localparam logic [15:0] ADT_RAW_ONES    = 16'hFFFF;
    localparam logic [15:0] ADT_RAW_ZERO    = 16'h0000;

    typedef enum logic [2:0] {
        ST_RST_SEQ,
        ST_FIRST,
        ST_CMD,
        ST_DATA,
        ST_DONE,
        ST_WAIT
    } state_e;

    // States that hold the chip select low.
    function automatic logic cs_active(state_e s);
        return (s == ST_RST_SEQ) || (s == ST_CMD) || (s == ST_DATA);
    endfunction

    function automatic logic raw_fault(logic [15:0] raw);
        return (raw == ADT_RAW_ONES) || (raw == ADT_RAW_ZERO);
    endfunction

    function automatic logic warm_next(
        logic               warm,
        logic signed [12:0] t,
        logic signed [12:0] on_th,
        logic signed [12:0] off_th
    );
        if (!warm && (t >= on_th)) return 1'b1;
        if (warm && (t < off_th))  return 1'b0;
        return warm;
    endfunction

endpackage

// File: rtl/temp_sensor_poller_spi_shift_engine.sv
// SPI mode-3 bit engine: SCLK divider, MSB-first shifter, MISO synchroniser.
module spi_shift_engine
    import temp_sensor_poller_pkg::*;
#(
    parameter int CLKDIV = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] txword_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic [15:0] rxword_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CW = $clog2(CLKDIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q;
    logic [5:0]    bits_q;
    logic [31:0]   tx_q;
    logic [15:0]   rx_q;
    logic [1:0]    sync_q;
    logic          busy_q;
    logic          low_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          tick;

    assign tick     = (cnt_q == CNT_LAST);
    assign done_o   = busy_q && !low_q && tick && (bits_q == 6'd0);
    assign busy_o   = busy_q;
    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign rxword_o = rx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            bits_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            sync_q <= '0;
            busy_q <= 1'b0;
            low_q  <= 1'b0;
            sclk_q <= 1'b1;
            mosi_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], miso_i};
            if (start_i && !busy_q) begin
                // Count starts at 1 so the start cycle belongs to the lead half-period.
                busy_q <= 1'b1;
                low_q  <= 1'b0;
                cnt_q  <= CW'(1);
                bits_q <= nbits_i;
                tx_q   <= txword_i << (6'd32 - nbits_i);
                rx_q   <= '0;
            end else if (busy_q) begin
                if (!tick) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    cnt_q <= '0;
                    if (!low_q) begin
                        if (bits_q == 6'd0) begin
                            busy_q <= 1'b0;
                            mosi_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            mosi_q <= tx_q[31];
                            tx_q   <= tx_q << 1;
                            low_q  <= 1'b1;
                        end
                    end else begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[14:0], sync_q[1]};
                        bits_q <= bits_q - 6'd1;
                        low_q  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/temp_sensor_poller.sv
// Periodic ADT7311 temperature reader with fault detect and hysteretic WARM flag.
module temp_sensor_poller
    import temp_sensor_poller_pkg::*;
#(
    parameter int                 CLKDIV      = 12,
    parameter int                 POLL_PERIOD = 4800000,
    parameter int                 FIRST_WAIT  = 3,
    parameter logic signed [12:0] WARM_ON     = 13'sd640,
    parameter logic signed [12:0] WARM_OFF    = 13'sd560
) (
    input  logic        MCLK,
    input  logic        nRESET,
    output logic        nTEMPCS,
    output logic        TEMPMOSI,
    input  logic        TEMPMISO,
    output logic        TEMPCLK,
    output logic [12:0] TEMP,
    output logic        TEMPVALID,
    output logic        WARM,
    output logic        FAULT
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [7:0]    PER_LAST  = 8'(FIRST_WAIT - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [7:0]    per_q, per_d;
    logic          launched_q, launched_d;
    logic          cs_q, cs_d;
    logic [12:0]   temp_q, temp_d;
    logic          valid_q, valid_d;
    logic          warm_q, warm_d;
    logic          fault_q, fault_d;

    logic          start;
    logic [5:0]    nbits;
    logic [31:0]   txword;
    logic [15:0]   rxword;
    logic          busy;
    logic          done;
    logic          poll_wrap;

    spi_shift_engine #(
        .CLKDIV(CLKDIV)
    ) u_spi (
        .clk_i   (MCLK),
        .rst_ni  (nRESET),
        .start_i (start),
        .nbits_i (nbits),
        .txword_i(txword),
        .miso_i  (TEMPMISO),
        .sclk_o  (TEMPCLK),
        .mosi_o  (TEMPMOSI),
        .rxword_o(rxword),
        .busy_o  (busy),
        .done_o  (done)
    );

    assign poll_wrap = (poll_q == POLL_LAST);

    always_comb begin
        state_d = state_q;
        poll_d  = poll_wrap ? '0 : poll_q + PW'(1);
        per_d   = per_q;
        temp_d  = temp_q;
        valid_d = 1'b0;
        warm_d  = warm_q;
        fault_d = fault_q;
        nbits   = 6'd0;
        txword  = '1;
        unique case (state_q)
            ST_RST_SEQ: begin
                nbits = 6'(ADT_RST_BITS);
                if (done) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                if (poll_wrap) begin
                    if (per_q == PER_LAST) state_d = ST_CMD;
                    else                   per_d   = per_q + 8'd1;
                end
            end
            ST_CMD: begin
                nbits  = 6'd8;
                txword = {24'h0, ADT_CMD_RD_TEMP};
                if (done) state_d = ST_DATA;
            end
            ST_DATA: begin
                nbits = 6'd16;
                if (done) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_WAIT;
                if (raw_fault(rxword)) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = 1'b0;
                    temp_d  = rxword[15:3];
                    valid_d = 1'b1;
                    warm_d  = warm_next(warm_q, $signed(rxword[15:3]),
                                        WARM_ON, WARM_OFF);
                end
            end
            ST_WAIT: begin
                if (poll_wrap) state_d = ST_CMD;
            end
            default: state_d = ST_RST_SEQ;
        endcase
        if ((state_d != state_q) &&
            ((state_d == ST_FIRST) || (state_d == ST_CMD))) begin
            poll_d = '0;
        end
        if ((state_d == ST_FIRST) && (state_q != ST_FIRST)) per_d = '0;
        // One engine launch per state, once the chip select is already low.
        start      = cs_active(state_q) && !launched_q && !cs_q && !busy;
        launched_d = (state_d == state_q) && (launched_q || start);
        cs_d       = !cs_active(state_d);
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_RST_SEQ;
            poll_q     <= '0;
            per_q      <= '0;
            launched_q <= 1'b0;
            cs_q       <= 1'b1;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            warm_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_q     <= poll_d;
            per_q      <= per_d;
            launched_q <= launched_d;
            cs_q       <= cs_d;
            temp_q     <= temp_d;
            valid_q    <= valid_d;
            warm_q     <= warm_d;
            fault_q    <= fault_d;
        end
    end

    assign nTEMPCS   = cs_q;
    assign TEMP      = temp_q;
    assign TEMPVALID = valid_q;
    assign WARM      = warm_q;
    assign FAULT     = fault_q;

endmodule

// File: tb/tb_temp_sensor_poller.sv
// Directed bench for temp_sensor_poller with a behavioural ADT7311 (mode 3).
module tb_temp_sensor_poller;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nTEMPCS;
    logic        TEMPMOSI;
    logic        TEMPMISO = 1'b0;
    logic        TEMPCLK;
    logic [12:0] TEMP;
    logic        TEMPVALID;
    logic        WARM;
    logic        FAULT;

    int checks = 0;
    int failures = 0;

    temp_sensor_poller #(
        .CLKDIV     (12),
        .POLL_PERIOD(2000),
        .FIRST_WAIT (1)
    ) dut (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .nTEMPCS  (nTEMPCS),
        .TEMPMOSI (TEMPMOSI),
        .TEMPMISO (TEMPMISO),
        .TEMPCLK  (TEMPCLK),
        .TEMP     (TEMP),
        .TEMPVALID(TEMPVALID),
        .WARM     (WARM),
        .FAULT    (FAULT)
    );

    always #5 MCLK = ~MCLK;

    // Sensor model and SPI observers
    logic [15:0] resp_next = 16'h0000;
    logic [15:0] resp_f = 16'h0000;
    logic [31:0] cap = '0, last_cap = '0;
    int   falls = 0, rises = 0, last_falls = 0, last_rises = 0;
    int   cs_rise_cnt = 0, cs_fall_cnt = 0;
    time  cs_rise_t = 0, cs_fall_t = 0, gap_t = 0, period_t = 0;
    time  sclk_fall_t = 0, sclk_rise_t = 0, lo_len = 0, hi_len = 0;
    logic cs_prev, sclk_prev;

    always @(nTEMPCS or TEMPCLK) begin
        if (nTEMPCS !== cs_prev) begin
            if (nTEMPCS === 1'b0) begin
                resp_f = resp_next;
                falls = 0;
                rises = 0;
                cap = '0;
                gap_t = $time - cs_rise_t;
                period_t = $time - cs_fall_t;
                cs_fall_t = $time;
                cs_fall_cnt++;
            end else if (nTEMPCS === 1'b1) begin
                last_cap = cap;
                last_rises = rises;
                last_falls = falls;
                cs_rise_t = $time;
                cs_rise_cnt++;
            end
            cs_prev = nTEMPCS;
        end
        if (TEMPCLK !== sclk_prev) begin
            if (nTEMPCS === 1'b0 && TEMPCLK === 1'b0) begin
                if (falls > 0) hi_len = $time - sclk_rise_t;
                sclk_fall_t = $time;
                TEMPMISO = (falls >= 8 && falls < 24) ? resp_f[23-falls] : 1'b0;
                falls++;
            end else if (nTEMPCS === 1'b0 && TEMPCLK === 1'b1) begin
                lo_len = $time - sclk_fall_t;
                sclk_rise_t = $time;
                cap = {cap[30:0], TEMPMOSI};
                rises++;
            end
            sclk_prev = TEMPCLK;
        end
    end

    int vcount = 0;
    always @(negedge MCLK) if (TEMPVALID === 1'b1) vcount++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(input string tag);
        int c0 = cs_rise_cnt;
        logic ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge MCLK);
            if (cs_rise_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_cs_rise"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_fall(input string tag);
        int c0 = cs_fall_cnt;
        logic ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge MCLK);
            if (cs_fall_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_cs_fall"}, 32'(ok), 32'd1);
    endtask

    // raw frame, expected TEMP, WARM, FAULT, TEMPVALID pulses
    localparam int NF = 10;
    logic [15:0] f_raw  [NF] = '{16'h1400, 16'h1200, 16'h1178, 16'h1400,
                                 16'hFFFF, 16'h0000, 16'h1180, 16'hFF80,
                                 16'h13F8, 16'h1400};
    logic [12:0] f_temp [NF] = '{13'h0280, 13'h0240, 13'h022F, 13'h0280,
                                 13'h0280, 13'h0280, 13'h0230, 13'h1FF0,
                                 13'h027F, 13'h0280};
    logic        f_warm [NF] = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 1};
    logic        f_flt  [NF] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int          f_dv   [NF] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};

    initial begin
        int v0;
        logic ok;
        resp_next = 16'h1900;
        repeat (4) @(negedge MCLK);
        check("reset_outs", {nTEMPCS, TEMPCLK, TEMPMOSI, TEMPVALID,
                             WARM, FAULT, TEMP}, {6'b111000, 13'h0});

        nRESET = 1'b1;
        wait_rise("rstseq");
        check("rstseq_falls", last_falls, 32);
        check("rstseq_rises", last_rises, 32);
        check("rstseq_mosi", last_cap, 32'hFFFF_FFFF);
        wait_fall("first");
        check("first_gap", 32'(gap_t), 32'd20000);

        wait_rise("f50");
        check("cmd_rises", last_rises, 24);
        check("cmd_mosi", last_cap[23:0], 24'h50FFFF);
        check("sclk_low", 32'(lo_len), 32'd120);
        check("sclk_high", 32'(hi_len), 32'd120);
        repeat (3) @(negedge MCLK);
        check("f50_temp", TEMP, 13'h0320);
        check("f50_warm", WARM, 1'b1);
        check("f50_fault", FAULT, 1'b0);
        check("f50_valid", vcount, 1);

        for (int k = 0; k < NF; k++) begin
            resp_next = f_raw[k];
            v0 = vcount;
            wait_rise("frame");
            repeat (3) @(negedge MCLK);
            check($sformatf("f%0d_temp", k), TEMP, f_temp[k]);
            check($sformatf("f%0d_warm", k), WARM, f_warm[k]);
            check($sformatf("f%0d_fault", k), FAULT, f_flt[k]);
            check($sformatf("f%0d_valid", k), vcount - v0, f_dv[k]);
        end
        check("poll_period", 32'(period_t), 32'd20000);

        resp_next = 16'h1900;
        v0 = vcount;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge MCLK);
            if (nTEMPCS === 1'b0 && falls >= 19) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_data_reach", 32'(ok), 32'd1);
        nRESET = 1'b0;
        #1;
        check("mid_reset_outs", {nTEMPCS, TEMPCLK, TEMPMOSI, TEMPVALID,
                                 WARM, FAULT, TEMP}, {6'b111000, 13'h0});
        repeat (5) @(negedge MCLK);
        nRESET = 1'b1;
        wait_rise("rerst");
        check("rerst_rises", last_rises, 32);
        check("rerst_mosi", last_cap, 32'hFFFF_FFFF);
        repeat (3) @(negedge MCLK);
        check("abort_valid", vcount - v0, 0);
        check("abort_temp", TEMP, 13'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
